// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared types and constants for the adder core sequencer.
// Provides the sequencer state enum, the operand-pair record stored in the
// FIFO, the data width and the counter-width helper.
package adder_seq_pkg;

    localparam int DATA_W          = 32;
    localparam int CORE_CYCLES_DEF = 12;

    // The counter must be able to hold CORE_CYCLES.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int CNT_W = $clog2(CORE_CYCLES_DEF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/adder_op_fifo.sv
// adder_op_fifo: synchronous FIFO holding queued operand pairs.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: full is low only when space is free; pushes while full and pops while empty are ignored.
// Ports: clk/rst (sync, active-high); push/wdata/full (write side); pop/rdata/empty (read side,
// rdata is the current head and is valid whenever empty is low).
module adder_op_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: sequencer feeding operand pairs to the byte-serial 32-bit adder core.
// Latency: with an empty FIFO, m_valid rises CORE_CYCLES+2 edges after the s handshake edge.
// Backpressure: m_ready low parks the result in HOLD; the FIFO keeps accepting until full (s_ready low).
// Ports: clk/rst (sync, active-high); s_valid/s_ready/s_op_a/s_op_b operand input;
// m_valid/m_ready/m_sum/m_carry/m_sovf result output; busy; core_en/core_in1/core_in2 drive
// the core, core_out/core_ovf are its sum and carry-out.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2,
    parameter int CORE_CYCLES = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_op_a,
    input  logic [DATA_W-1:0] s_op_b,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_sum,
    output logic              m_carry,
    output logic              m_sovf,
    output logic              busy,
    output logic              core_en,
    output logic [DATA_W-1:0] core_in1,
    output logic [DATA_W-1:0] core_in2,
    input  logic [DATA_W-1:0] core_out,
    input  logic              core_ovf
);

    // The core rotates through four byte stages; enabling it for a whole number
    // of rotations (at least three) leaves it back at stage 0 with a settled result.
    if ((CORE_CYCLES % 4) != 0 || CORE_CYCLES < 12) begin : g_bad_core_cycles
        $error("adder_seq_ctrl: CORE_CYCLES must be a multiple of 4 and at least 12");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("adder_seq_ctrl: FIFO_DEPTH must be a power of two and at least 2");
    end

    localparam int            CW       = cnt_width(CORE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(CORE_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    op_pair_t      op;
    op_pair_t      head;
    op_pair_t      wr_pair;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign wr_pair.a = s_op_a;
    assign wr_pair.b = s_op_b;

    adder_op_fifo #(
        .WIDTH ($bits(op_pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .wdata (wr_pair),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty)
    );

    assign s_ready  = !fifo_full;
    assign core_in1 = op.a;
    assign core_in2 = op.b;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty)     state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = SAMPLE;
            SAMPLE:                       state_nxt = HOLD;
            HOLD:    if (m_ready)         state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        core_en = 1'b0;
        pop     = 1'b0;
        busy    = !fifo_empty;
        case (state)
            IDLE:    pop     = !fifo_empty;
            RUN: begin
                core_en = 1'b1;
                busy    = 1'b1;
            end
            default: busy    = 1'b1;
        endcase
    end

    // Operand latch, run counter and result registers. The operands stay
    // latched from the pop until the next pop so core_in1/2 are steady in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op      <= '0;
            m_valid <= 1'b0;
            m_sum   <= '0;
            m_carry <= 1'b0;
            m_sovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        op  <= head;
                        cnt <= '0;
                    end
                end
                RUN: cnt <= cnt + 1'b1;
                SAMPLE: begin
                    m_sum   <= core_out;
                    m_carry <= core_ovf;
                    // Signed overflow: like-signed operands producing an opposite-signed sum.
                    m_sovf  <= (op.a[DATA_W-1] == op.b[DATA_W-1]) &&
                               (core_out[DATA_W-1] != op.a[DATA_W-1]);
                    m_valid <= 1'b1;
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                default: m_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: checks adder_seq_ctrl driving a behavioural byte-serial adder core.
// Directed vector table plus hand-written multi-cycle sequences and a randomized run,
// all scored against a plain A+B reference model.
module tb_adder_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_op_a;
    logic [31:0] s_op_b;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_sum;
    logic        m_carry;
    logic        m_sovf;
    logic        busy;
    logic        core_en;
    logic [31:0] core_in1;
    logic [31:0] core_in2;
    logic [31:0] core_out;
    logic        core_ovf;

    always #5 clk = ~clk;

    adder_seq_ctrl #(
        .FIFO_DEPTH  (2),
        .CORE_CYCLES (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_op_a   (s_op_a),
        .s_op_b   (s_op_b),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sum    (m_sum),
        .m_carry  (m_carry),
        .m_sovf   (m_sovf),
        .busy     (busy),
        .core_en  (core_en),
        .core_in1 (core_in1),
        .core_in2 (core_in2),
        .core_out (core_out),
        .core_ovf (core_ovf)
    );

    // Behavioural byte-serial core: one byte per enabled cycle, stage 0 takes no carry-in,
    // carry-out of stage 3 is the overflow flag. Reset shares rst (its rst_n is ~rst).
    logic [1:0] core_stage;
    logic       core_cy;
    logic [8:0] core_t;

    assign core_t = {1'b0, core_in1[int'(core_stage)*8 +: 8]} +
                    {1'b0, core_in2[int'(core_stage)*8 +: 8]} +
                    ((core_stage == 2'd0) ? 9'd0 : {8'd0, core_cy});

    always @(posedge clk) begin
        if (rst) begin
            core_stage <= 2'd0;
            core_cy    <= 1'b0;
            core_out   <= 32'd0;
            core_ovf   <= 1'b0;
        end else if (core_en) begin
            core_out[int'(core_stage)*8 +: 8] <= core_t[7:0];
            core_cy    <= core_t[8];
            if (core_stage == 2'd3) core_ovf <= core_t[8];
            core_stage <= core_stage + 2'd1;
        end
    end

    // Reference model and scoreboard
    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic        sovf;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
        logic        sovf;
    } vec_t;

    res_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_results = 0;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [32:0] s;
        s       = {1'b0, a} + {1'b0, b};
        r.sum   = s[31:0];
        r.carry = s[32];
        r.sovf  = (a[31] == b[31]) && (s[31] != a[31]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Handshakes are sampled on the falling edge; the values hold until the next rising edge.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (m_valid && m_ready) begin
                n_results++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: result 0x%0h with no operand pair outstanding", m_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sum",   m_sum,   e.sum);
                    check("sb_carry", m_carry, e.carry);
                    check("sb_sovf",  m_sovf,  e.sovf);
                end
            end
            if (s_valid && s_ready) exp_q.push_back(model(s_op_a, s_op_b));
        end
    end

    // Present one pair and hold it until accepted; returns 1 time unit after the handshake edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        s_op_a  = a;
        s_op_b  = b;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            n_fail++;
            $display("FAIL send_timeout: s_ready stayed 0, expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || m_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_within_budget", {62'd0, busy, m_valid}, 64'd0);
    endtask

    // Single op from an empty, idle sequencer with m_ready high: checks latency,
    // number of enabled core cycles and the result fields.
    task automatic run_vec(input vec_t v);
        int lat = 0;
        int en  = 0;
        send(v.a, v.b);
        while (!m_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (core_en) en++;
        end
        check("latency",     lat,     14);
        check("core_en_cyc", en,      12);
        check("vec_sum",     m_sum,   v.sum);
        check("vec_carry",   m_carry, v.carry);
        check("vec_sovf",    m_sovf,  v.sovf);
        wait_idle(20);
    endtask

    vec_t vecs[8];
    res_t r;
    int   r0;
    int   bad;
    int   w;
    bit   stop;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, sum: 32'h0000_0000, carry: 1'b1, sovf: 1'b0};
        vecs[1] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, sum: 32'h8000_0000, carry: 1'b0, sovf: 1'b1};
        vecs[2] = '{a: 32'h8000_0000, b: 32'h8000_0000, sum: 32'h0000_0000, carry: 1'b1, sovf: 1'b1};
        vecs[3] = '{a: 32'h1234_5678, b: 32'h1111_1111, sum: 32'h2345_6789, carry: 1'b0, sovf: 1'b0};
        vecs[4] = '{a: 32'h0000_0000, b: 32'h0000_0000, sum: 32'h0000_0000, carry: 1'b0, sovf: 1'b0};
        vecs[5] = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, sum: 32'h7FFF_FFFF, carry: 1'b1, sovf: 1'b1};
        vecs[6] = '{a: 32'h4000_0000, b: 32'h4000_0000, sum: 32'h8000_0000, carry: 1'b0, sovf: 1'b1};
        vecs[7] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, sum: 32'hFFFF_FFFE, carry: 1'b1, sovf: 1'b0};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_op_a  = 32'd0;
        s_op_b  = 32'd0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_s_ready",  s_ready,  1);
        check("rst_m_valid",  m_valid,  0);
        check("rst_m_sum",    m_sum,    0);
        check("rst_m_carry",  m_carry,  0);
        check("rst_m_sovf",   m_sovf,   0);
        check("rst_busy",     busy,     0);
        check("rst_core_en",  core_en,  0);
        check("rst_core_in1", core_in1, 0);
        check("rst_core_in2", core_in2, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Three pairs back-to-back: FIFO fills on the third, results drain in order.
        r0 = n_results;
        send(32'h0000_0010, 32'h0000_0020);
        send(32'hFFFF_FFF0, 32'h0000_0020);
        send(32'h7000_0000, 32'h1000_0000);
        check("b2b_s_ready_third", s_ready, 0);
        wait_idle(200);
        check("b2b_result_count", n_results - r0, 3);

        // Result backpressure for 40 cycles
        m_ready = 1'b0;
        r0 = n_results;
        send(32'hA5A5_A5A5, 32'h5A5A_5A5B);
        send(32'h0000_0003, 32'h0000_0004);
        send(32'h0F0F_0F0F, 32'h0101_0101);
        w = 0;
        while (!m_valid && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        r   = model(32'hA5A5_A5A5, 32'h5A5A_5A5B);
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (m_sum !== r.sum || m_valid !== 1'b1) bad++;
        end
        check("bp_hold_stable",  bad,            0);
        check("bp_m_carry",      m_carry,        r.carry);
        check("bp_s_ready_full", s_ready,        0);
        check("bp_no_release",   n_results - r0, 0);
        m_ready = 1'b1;
        wait_idle(200);
        check("bp_result_count", n_results - r0, 3);

        // Reset while the op is in RUN with cnt=5
        r0 = n_results;
        send(32'hDEAD_BEEF, 32'h0102_0304);
        repeat (6) @(posedge clk);
        #1;
        check("mid_run_core_en", core_en, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_m_valid",  m_valid,  0);
        check("mrst_core_en",  core_en,  0);
        check("mrst_busy",     busy,     0);
        check("mrst_s_ready",  s_ready,  1);
        check("mrst_m_sum",    m_sum,    0);
        check("mrst_core_in1", core_in1, 0);
        check("mrst_core_in2", core_in2, 0);
        repeat (30) @(posedge clk);
        #1;
        check("mrst_no_result", n_results - r0, 0);
        run_vec(vecs[3]);

        // Randomized traffic with random result backpressure
        r0   = n_results;
        stop = 1'b0;
        fork
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    send($urandom, $urandom);
                end
                stop = 1'b1;
            end
        join
        m_ready = 1'b1;
        wait_idle(600);
        check("rand_result_count", n_results - r0, 25);
        check("rand_model_empty",  exp_q.size(),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
